// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Instruction memory with a streaming program loader and a single-cycle-latency
// fetch port. A program image arrives as a stream of beats after prog_start_i;
// the fetch port returns the stored instruction one cycle after a request,
// flagging misaligned or out-of-range addresses. Words at or beyond the current
// program length read back as 0 (NOP).
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous, active-high reset
//   fetch_req_i     fetch request (ignored while busy_o=1)
//   fetch_addr_i    byte address; word index = fetch_addr_i >> 1
//   fetch_valid_o   result valid, one cycle after an accepted request
//   fetch_data_o    fetched instruction (0 on fault or beyond prog_len_o)
//   fetch_fault_o   misaligned or out-of-range fetch
//   prog_start_i    begin a program load (only honoured when idle)
//   prog_valid_i    load beat valid
//   prog_data_i     load beat instruction
//   prog_last_i     final beat marker
//   prog_ready_o    loader accepts a beat
//   prog_len_o      number of words currently loaded
//   prog_overflow_o sticky: image exceeded DEPTH words
//   busy_o          load in progress
// -----------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int INST_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH),
  localparam int LEN_W     = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_valid_o,
  output logic [INST_WIDTH-1:0] fetch_data_o,
  output logic                  fetch_fault_o,
  input  logic                  prog_start_i,
  input  logic                  prog_valid_i,
  input  logic [INST_WIDTH-1:0] prog_data_i,
  input  logic                  prog_last_i,
  output logic                  prog_ready_o,
  output logic [LEN_W-1:0]      prog_len_o,
  output logic                  prog_overflow_o,
  output logic                  busy_o
);

  typedef enum logic {IDLE, LOAD} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            mem_we;

  logic [INST_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Loader FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // prog_valid_i is deliberately not looked at here: beats outside a load
        // must never reach the array.
        if (prog_start_i) begin
          state_d = LOAD;
          ptr_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      LOAD: begin
        // prog_start_i is ignored here, so a stray pulse cannot rewind ptr.
        if (prog_valid_i && ready_q) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          len_d  = len_q + LEN_W'(1);
          if (prog_last_i || ptr_q == AW'(DEPTH - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b0;
            // Filling the last slot without seeing the end marker means the
            // image did not fit.
            if (!prog_last_i) ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // NOTE: the array has no reset; stale contents stay unreachable because
  // prog_len drops to 0 and reads beyond it return NOP.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= prog_data_i;
  end

  // ---------------------------------------------------------------------------
  // Fetch port
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-2:0] word_idx;
  logic [AW-1:0]         mem_idx;
  logic                  fetch_take;
  logic                  out_of_range;
  logic                  fault;
  logic                  beyond_len;

  assign word_idx     = fetch_addr_i[ADDR_WIDTH-1:1];
  // Upper index bits only feed the range check, so large addresses fault
  // instead of aliasing onto low words.
  assign mem_idx      = word_idx[AW-1:0];
  assign out_of_range = {1'b0, word_idx} >= ADDR_WIDTH'(DEPTH);
  assign fault        = fetch_addr_i[0] | out_of_range;
  assign beyond_len   = {1'b0, mem_idx} >= len_q;
  assign fetch_take   = fetch_req_i & ~busy_q;

  logic                  fetch_valid_q;
  logic                  fetch_fault_q;
  logic [INST_WIDTH-1:0] fetch_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      fetch_valid_q <= fetch_take;
      fetch_fault_q <= fetch_take & fault;
      fetch_data_q  <= (fetch_take && !fault && !beyond_len) ? mem[mem_idx] : '0;
    end
  end

  assign fetch_valid_o   = fetch_valid_q;
  assign fetch_fault_o   = fetch_fault_q;
  assign fetch_data_o    = fetch_data_q;
  assign prog_ready_o    = ready_q;
  assign busy_o          = busy_q;
  assign prog_len_o      = len_q;
  assign prog_overflow_o = ovf_q;

endmodule
